// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its matching detector.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAPST = 2'd2
  } state_t;

  localparam logic [3:0] SEQ_PATTERN = 4'b0110;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_generator_piso.sv
// W-bit parallel-in serial-out shift register; load wins over shift, MSB leaves first.
module piso_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] din_i,
  output logic         msb_o
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;
  logic [W-1:0] shifted;

  assign shifted[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < W; gi++) begin : g_shift
      assign shifted[gi] = shreg_q[gi-1];
    end
  endgenerate

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = din_i;
    end else if (shift_i) begin
      shreg_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a latched W-bit pattern MSB-first, N times,
// with optional idle gaps between passes. All outputs come straight from flops.
module seq_generator
  import seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = cnt_width(W);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             piso_load;
  logic             piso_shift;
  logic             piso_msb;
  logic [W-1:0]     src_pat;
  logic [W-1:0]     piso_din;

  // The MSB goes straight to x on load, so the shifter only holds the bits still to come.
  assign src_pat  = (state_q == IDLE) ? pattern : pat_q;
  assign piso_din = {src_pat[W-2:0], 1'b0};

  piso_reg #(
    .W (W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .din_i   (piso_din),
    .msb_o   (piso_msb)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    x_d        = 1'b0;
    x_valid_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          rep_d     = (reps == '0) ? CNT_W'(1) : reps;
          bit_d     = '0;
          x_d       = pattern[W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          piso_load = 1'b1;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (bit_q != BIT_LAST) begin
          x_d        = piso_msb;
          x_valid_d  = 1'b1;
          busy_d     = 1'b1;
          piso_shift = 1'b1;
          bit_d      = bit_q + 1'b1;
        end else begin
          rep_d = rep_q - 1'b1;
          if (rep_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = GAPST;
            gap_d   = '0;
            busy_d  = 1'b1;
          end else begin
            // Back-to-back pass: next MSB follows the last bit with no dead cycle.
            x_d       = pat_q[W-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            piso_load = 1'b1;
            bit_d     = '0;
          end
        end
      end

      GAPST: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          x_d       = pat_q[W-1];
          x_valid_d = 1'b1;
          piso_load = 1'b1;
          bit_d     = '0;
          state_d   = SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: a GAP=0 and a GAP=2 instance checked every cycle
// against a per-cycle expectation queue built from the pattern/reps rules.
module tb_seq_generator;
  import seq_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic x;
    logic xv;
    logic busy;
    logic done;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             start0, start1;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] reps;
  logic             x0, xv0, busy0, done0;
  logic             x1, xv1, busy1, done1;

  int tests = 0;
  int fails = 0;

  ent_t mcur [2];
  ent_t mq   [2][$];

  logic       lb_en = 1'b0;
  logic [3:0] lb_win = 4'b0;
  int         lb_hits = 0;

  seq_generator #(.W(W), .CNT_W(CNT_W), .GAP(0)) dut0 (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start0),
    .pattern (pattern),
    .reps    (reps),
    .x       (x0),
    .x_valid (xv0),
    .busy    (busy0),
    .done    (done0)
  );

  seq_generator #(.W(W), .CNT_W(CNT_W), .GAP(2)) dut2 (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start1),
    .pattern (pattern),
    .reps    (reps),
    .x       (x1),
    .x_valid (xv1),
    .busy    (busy1),
    .done    (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("g0.x",       x0,    mcur[0].x);
    chk("g0.x_valid", xv0,   mcur[0].xv);
    chk("g0.busy",    busy0, mcur[0].busy);
    chk("g0.done",    done0, mcur[0].done);
    chk("g2.x",       x1,    mcur[1].x);
    chk("g2.x_valid", xv1,   mcur[1].xv);
    chk("g2.busy",    busy1, mcur[1].busy);
    chk("g2.done",    done1, mcur[1].done);
    if (lb_en && xv0) begin
      lb_win = {lb_win[2:0], x0};
      if (lb_win == SEQ_PATTERN) lb_hits++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mcur[i] = '0;
      mq[i].delete();
    end
  endtask

  // One clock edge of the reference: a transmission is the list of cycles
  // N passes of W bits, GAP idle cycles between passes, then one done cycle.
  task automatic model_edge(input int i, input int g, input logic st);
    ent_t e;
    int   n;
    if (mcur[i].busy) begin
      if (mq[i].size() > 0) mcur[i] = mq[i].pop_front();
      else mcur[i] = '{x: 1'b0, xv: 1'b0, busy: 1'b0, done: 1'b1};
    end else if (st) begin
      n = (reps == 0) ? 1 : int'(reps);
      for (int r = 0; r < n; r++) begin
        for (int b = 0; b < W; b++) begin
          e = '{x: pattern[W-1-b], xv: 1'b1, busy: 1'b1, done: 1'b0};
          mq[i].push_back(e);
        end
        if (r < n - 1) begin
          for (int k = 0; k < g; k++) begin
            e = '{x: 1'b0, xv: 1'b0, busy: 1'b1, done: 1'b0};
            mq[i].push_back(e);
          end
        end
      end
      mcur[i] = mq[i].pop_front();
    end else begin
      mcur[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      model_edge(0, 0, start0);
      model_edge(1, 2, start1);
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_all();
    tick();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    pattern = '0;
    reps    = '0;
    model_clear();

    // Reset state, then idle with start low.
    #1 check_all();
    ticks(2);
    #2 rst_n = 1'b1;
    ticks(3);

    // Single pass of the shared default pattern.
    pattern = SEQ_PATTERN; reps = 4'd1; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(7);

    // Three passes: gapped on one instance, back-to-back on the other.
    pattern = 4'b1011; reps = 4'd3; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(20);

    // Start re-pulsed with a different pattern mid-transmission is ignored.
    pattern = 4'b0110; reps = 4'd2; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(3);
    pattern = 4'b1111; reps = 4'd5; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(20);

    // reps=0 behaves as one pass.
    pattern = 4'b1000; reps = 4'd0; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(7);

    // Start held high: restart on the edge ending each done cycle.
    pattern = 4'b1001; reps = 4'd2; start0 = 1'b1; start1 = 1'b1;
    ticks(30);
    start0 = 1'b0; start1 = 1'b0;
    ticks(14);

    // Reset during bit 2, then a fresh transmission from its MSB.
    pattern = 4'b1101; reps = 4'd3; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(2);
    async_reset();
    ticks(3);
    pattern = 4'b0110; reps = 4'd1; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(7);

    // Maximum repetition count.
    pattern = 4'b1010; reps = 4'd15; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    ticks(95);

    // Randomized starts, patterns and counts.
    for (int c = 0; c < 600; c++) begin
      start0  = ($urandom_range(0, 4) == 0);
      start1  = ($urandom_range(0, 4) == 0);
      pattern = W'($urandom);
      reps    = ($urandom_range(0, 9) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 3));
      tick();
    end
    start0 = 1'b0; start1 = 1'b0;
    ticks(100);

    // Loopback stream 01100110 must contain the detector pattern twice.
    lb_en = 1'b1; lb_win = '0; lb_hits = 0;
    pattern = SEQ_PATTERN; reps = 4'd2; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ticks(10);
    lb_en = 1'b0;
    tests++;
    assert (lb_hits == 2) else begin
      fails++;
      $error("FAIL loopback_hits: observed %0d expected 2", lb_hits);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
